v1_pulse_gen: RTL and testbench

V1_PULSE_GEN -- requirements
Module: v1_pulse_gen

---
 rtl/v1_parameter.sv | 4 +
 rtl/v1_pulse_gen.sv | 103 ++++++++++
 tb/tb_v1_pulse_gen.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/v1_parameter.sv
// v1_parameter: shared widths for the v1 acquisition chain.
package v1_parameter;
    localparam int SIZE_ADC_DATA = 12;
endpackage

// File: rtl/v1_pulse_gen.sv
// v1_pulse_gen: synthetic ADC pulse source -- linear rise, exponential decay, then a dead time.
module v1_pulse_gen #(
    parameter int SIZE_ADC_DATA  = v1_parameter::SIZE_ADC_DATA,
    parameter int RISE_SHIFT     = 2,
    parameter int DECAY_SHIFT    = 7,
    parameter int DECAY_CYCLES   = 512,
    parameter int HOLDOFF_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [SIZE_ADC_DATA-1:0] amplitude,
    input  logic [SIZE_ADC_DATA-1:0] baseline,
    output logic [SIZE_ADC_DATA-1:0] output_data,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               missed
);
    localparam int AW = SIZE_ADC_DATA + 8;
    localparam int RW = RISE_SHIFT + 1;
    localparam int DW = $clog2(DECAY_CYCLES) + 1;
    localparam int HW = $clog2(HOLDOFF_CYCLES) + 1;
    localparam logic [RW-1:0] RISE_LAST = RW'((1 << RISE_SHIFT) - 1);
    localparam logic [DW-1:0] DEC_LAST  = DW'(DECAY_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RISE, DECAY, HOLDOFF} state_t;

    state_t                   state;
    logic [SIZE_ADC_DATA-1:0] amp_r;
    logic [AW-1:0]            acc;
    logic [AW-1:0]            step;
    logic [AW-1:0]            decayed;
    logic [RW-1:0]            rise_cnt;
    logic [DW-1:0]            dcnt;
    logic [HW-1:0]            hcnt;
    logic [SIZE_ADC_DATA:0]   sum;
    logic                     dec_exit;

    // acc carries 8 fractional bits; only its integer part reaches the output
    always_comb begin
        step     = {amp_r, 8'd0} >> RISE_SHIFT;
        decayed  = acc - (acc >> DECAY_SHIFT);
        sum      = {1'b0, baseline} + {1'b0, acc[AW-1:8]};
        dec_exit = (dcnt == DEC_LAST) || (acc[AW-1:8] == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            amp_r       <= '0;
            acc         <= '0;
            rise_cnt    <= '0;
            dcnt        <= '0;
            hcnt        <= '0;
            output_data <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            missed      <= '0;
        end else begin
            done        <= 1'b0;
            output_data <= sum[SIZE_ADC_DATA] ? '1 : sum[SIZE_ADC_DATA-1:0];
            if (start && state != IDLE && missed != 8'hFF)
                missed <= missed + 8'd1;
            case (state)
                IDLE: if (start) begin
                    amp_r    <= amplitude;
                    acc      <= '0;
                    rise_cnt <= '0;
                    busy     <= 1'b1;
                    state    <= RISE;
                end
                RISE: begin
                    rise_cnt <= rise_cnt + RW'(1);
                    // last rise step lands exactly on the peak, discarding truncation error
                    if (rise_cnt == RISE_LAST) begin
                        acc   <= {amp_r, 8'd0};
                        dcnt  <= '0;
                        state <= DECAY;
                    end else begin
                        acc <= acc + step;
                    end
                end
                DECAY: if (dec_exit) begin
                    acc   <= '0;
                    hcnt  <= '0;
                    done  <= 1'b1;
                    state <= HOLDOFF;
                end else begin
                    acc  <= decayed;
                    dcnt <= dcnt + DW'(1);
                end
                HOLDOFF: if (hcnt == HOLD_LAST) begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end else begin
                    hcnt <= hcnt + HW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_v1_pulse_gen.sv
// tb_v1_pulse_gen: randomized pulse checks against a fixed-point envelope model.
module tb_v1_pulse_gen;
    localparam int W    = 12;
    localparam int RS   = 2;
    localparam int DS   = 7;
    localparam int DC   = 512;
    localparam int HC   = 16;
    localparam int NR   = 1 << RS;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] amplitude = '0;
    logic [W-1:0] baseline = '0;
    logic [W-1:0] output_data;
    logic         busy;
    logic         done;
    logic [7:0]   missed;

    int vectors = 0;
    int miscompares = 0;
    int exp_missed = 0;
    int env[$];

    v1_pulse_gen #(
        .SIZE_ADC_DATA(W), .RISE_SHIFT(RS), .DECAY_SHIFT(DS),
        .DECAY_CYCLES(DC), .HOLDOFF_CYCLES(HC)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .amplitude(amplitude),
        .baseline(baseline), .output_data(output_data), .busy(busy),
        .done(done), .missed(missed)
    );

    always #5 clk = ~clk;

    // Integer part of the pulse envelope for each clock from the start edge until the decay ends.
    task automatic fill_env(input int amp);
        longint a = longint'(amp) * 256;
        longint stp = a / NR;
        env = {};
        for (int i = 0; i < NR; i++) env.push_back(int'((i * stp) >> 8));
        for (int n = 0; n < DC; n++) begin
            env.push_back(int'(a >> 8));
            if ((a >> 8) == 0 || n == DC - 1) break;
            a = a - a / (1 << DS);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 2000) begin @(negedge clk); n++; end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle timeout: busy=%b after %0d cycles, expected 0", tag, busy, n);
        end
    endtask

    task automatic run_pulse(input int amp, input int base, input bit wiggle);
        int b = base;
        int len;
        int eo;
        fill_env(amp);
        len = env.size();
        amplitude = W'(amp);
        baseline = W'(base);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j <= len + HC + 1; j++) begin
            eo = b + ((j >= 1 && j <= len) ? env[j-1] : 0);
            if (eo > MAXV) eo = MAXV;
            vectors++;
            if (output_data !== W'(eo) || busy !== (j <= len + HC - 1) || done !== (j == len)) begin
                miscompares++;
                $display("FAIL pulse amp=%0d j=%0d: out=%0d busy=%b done=%b, expected out=%0d busy=%b done=%b",
                         amp, j, output_data, busy, done, eo, j <= len + HC - 1, j == len);
            end
            if (wiggle) begin
                b = $urandom_range(0, MAXV);
                baseline = W'(b);
                amplitude = W'($urandom);
            end
            @(negedge clk);
        end
        vectors++;
        if (missed !== 8'(exp_missed)) begin
            miscompares++;
            $display("FAIL pulse missed: got %0d expected %0d", missed, exp_missed);
        end
    endtask

    task automatic test_reset;
        baseline = 12'd1234;
        amplitude = 12'd500;
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (output_data !== '0 || busy !== 1'b0 || done !== 1'b0 || missed !== '0) begin
                miscompares++;
                $display("FAIL reset hold: out=%0d busy=%b done=%b missed=%0d, expected all 0",
                         output_data, busy, done, missed);
            end
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (output_data !== 12'd1234 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset release: out=%0d busy=%b done=%b, expected 1234 0 0", output_data, busy, done);
        end
    endtask

    task automatic test_ramp_peak;
        int ramp[6] = '{350, 600, 850, 1100, 1092, 1084};
        int done_cnt = 0;
        int done_j = -1;
        int busy_hold = 0;
        int t;
        real r = 1000.0;
        amplitude = 12'd1000;
        baseline = 12'd100;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 600; j++) begin
            if (j >= 2 && j <= 7) begin
                vectors++;
                if (output_data !== W'(ramp[j-2]) || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ramp j=%0d: out=%0d busy=%b, expected %0d 1", j, output_data, busy, ramp[j-2]);
                end
            end
            if (j >= 5 && j <= 505) begin
                t = 100 + $rtoi($floor(r));
                r = r * 127.0 / 128.0;
                vectors++;
                if (int'(output_data) - t > 1 || t - int'(output_data) > 1) begin
                    miscompares++;
                    $display("FAIL decay n=%0d: out=%0d expected %0d +-1", j - 5, output_data, t);
                end
            end
            if (done) begin done_cnt++; done_j = j; end
            if (done_j >= 0 && busy) busy_hold++;
            @(negedge clk);
        end
        vectors++;
        if (done_cnt != 1 || busy_hold != HC) begin
            miscompares++;
            $display("FAIL done strobe: count=%0d busy_after=%0d, expected 1 %0d", done_cnt, busy_hold, HC);
        end
    endtask

    task automatic test_saturation;
        run_pulse(1000, 4000, 1'b0);
    endtask

    task automatic test_amp_zero;
        run_pulse(0, $urandom_range(0, MAXV), 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 4; i++)
            run_pulse($urandom_range(0, MAXV), $urandom_range(0, MAXV), i[0]);
    endtask

    task automatic test_holdoff_edge;
        amplitude = '0;
        baseline = W'($urandom_range(0, MAXV));
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (NR + HC) @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL holdoff last: busy=%b expected 1", busy);
        end
        start = 1'b1;
        @(negedge clk);
        exp_missed++;
        vectors++;
        if (busy !== 1'b0 || missed !== 8'(exp_missed)) begin
            miscompares++;
            $display("FAIL return edge start: busy=%b missed=%0d, expected 0 %0d", busy, missed, exp_missed);
        end
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || missed !== 8'(exp_missed)) begin
            miscompares++;
            $display("FAIL idle start: busy=%b missed=%0d, expected 1 %0d", busy, missed, exp_missed);
        end
        wait_idle("holdoff_edge");
    endtask

    task automatic test_missed;
        amplitude = W'($urandom_range(1000, MAXV));
        baseline = 12'd200;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (exp_missed < 255) exp_missed++;
            vectors++;
            if (missed !== 8'(exp_missed) || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL missed k=%0d: missed=%0d busy=%b, expected %0d 1", k, missed, busy, exp_missed);
            end
        end
        start = 1'b0;
        wait_idle("missed");
        vectors++;
        if (missed !== 8'd255) begin
            miscompares++;
            $display("FAIL missed hold: got %0d expected 255", missed);
        end
        run_pulse($urandom_range(0, MAXV), $urandom_range(0, 3000), 1'b0);
    endtask

    task automatic test_reset_mid_pulse;
        int dones = 0;
        amplitude = 12'd2000;
        baseline = 12'd500;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (output_data !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL async reset: out=%0d busy=%b done=%b, expected 0 0 0", output_data, busy, done);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_missed = 0;
        for (int j = 0; j < 600; j++) begin
            @(negedge clk);
            if (done) dones++;
            vectors++;
            if ((j >= 1 && output_data !== 12'd500) || busy !== 1'b0 || missed !== '0) begin
                miscompares++;
                $display("FAIL post reset j=%0d: out=%0d busy=%b missed=%0d, expected 500 0 0",
                         j, output_data, busy, missed);
            end
        end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("FAIL post reset done: %0d strobes, expected 0", dones);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_peak();
        test_saturation();
        test_amp_zero();
        test_random();
        test_holdoff_edge();
        test_missed();
        test_reset_mid_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
